// File: rtl/pwm_reg_bank.sv
// APB register bank for an NUM_CH-channel PWM core: control, sticky W1C status with
// interrupt, and per-channel PERIOD/DUTY shadows copied to active copies at period end.
module pwm_reg_bank #(
   parameter int NUM_CH     = 4,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        psel,
   input  logic                        penable,
   input  logic                        pwrite,
   input  logic [ADDR_WIDTH-1:0]       paddr,
   input  logic [DATA_WIDTH-1:0]       pwdata,
   output logic [DATA_WIDTH-1:0]       prdata,
   output logic                        pready,
   output logic                        pslverr,
   input  logic [NUM_CH-1:0]           period_end,
   input  logic [NUM_CH-1:0]           fault,
   output logic [NUM_CH-1:0]           pwm_en,
   output logic [NUM_CH*CNT_WIDTH-1:0] period_act,
   output logic [NUM_CH*CNT_WIDTH-1:0] duty_act,
   output logic                        irq
);
   localparam int SW = 2*NUM_CH;
   localparam int IW = ADDR_WIDTH-3;
   localparam logic [ADDR_WIDTH-1:0] A_CTRL  = ADDR_WIDTH'('h00);
   localparam logic [ADDR_WIDTH-1:0] A_STAT  = ADDR_WIDTH'('h04);
   localparam logic [ADDR_WIDTH-1:0] A_IEN   = ADDR_WIDTH'('h08);
   localparam logic [ADDR_WIDTH-1:0] A_UPD   = ADDR_WIDTH'('h0C);
   localparam logic [ADDR_WIDTH-1:0] A_CH0   = ADDR_WIDTH'('h10);
   localparam logic [ADDR_WIDTH:0]   A_CHEND = (ADDR_WIDTH+1)'(16 + 8*NUM_CH);

   logic                  access, addr_ok, wr, rd, force_upd;
   logic                  sel_ctrl, sel_stat, sel_ien, sel_upd, sel_ch;
   logic [ADDR_WIDTH-1:0] ch_off;
   logic [NUM_CH-1:0]     per_wr, duty_wr, xfer;
   logic [CNT_WIDTH-1:0]  ch_rdata;

   logic [NUM_CH-1:0]                ctrl_q, ctrl_d, upd_q, upd_d;
   logic [SW-1:0]                    stat_q, stat_d, ien_q, ien_d;
   logic                             irq_q, irq_d;
   logic [NUM_CH-1:0][CNT_WIDTH-1:0] psh_q, psh_d, dsh_q, dsh_d;
   logic [NUM_CH-1:0][CNT_WIDTH-1:0] pact_q, pact_d, dact_q, dact_d;

   logic unused_bits;
   assign unused_bits = ^{pwdata, ch_off[1:0]};

   // Response is gated by reset_n so an access phase held across reset reports nothing.
   assign access   = reset_n & psel & penable;
   assign sel_ctrl = (paddr == A_CTRL);
   assign sel_stat = (paddr == A_STAT);
   assign sel_ien  = (paddr == A_IEN);
   assign sel_upd  = (paddr == A_UPD);
   assign sel_ch   = (paddr >= A_CH0) && ({1'b0, paddr} < A_CHEND);
   assign ch_off   = paddr - A_CH0;
   assign addr_ok  = (paddr[1:0] == 2'b00) &&
                     (sel_ctrl | sel_stat | sel_ien | (sel_upd & ~pwrite) | sel_ch);

   assign pready    = access;
   assign pslverr   = access & ~addr_ok;
   assign wr        = access & pwrite & addr_ok;
   assign rd        = access & ~pwrite & addr_ok;
   assign force_upd = wr & sel_ctrl & pwdata[31];
   assign xfer      = force_upd ? '1 : (period_end & upd_q);

   always_comb begin
      per_wr   = '0;
      duty_wr  = '0;
      ch_rdata = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (sel_ch && (ch_off[ADDR_WIDTH-1:3] == IW'(c))) begin
            per_wr[c]  = wr & ~ch_off[2];
            duty_wr[c] = wr &  ch_off[2];
            ch_rdata   = ch_off[2] ? dsh_q[c] : psh_q[c];
         end
      end
   end

   always_comb begin
      ctrl_d = ctrl_q;
      ien_d  = ien_q;
      stat_d = stat_q;
      psh_d  = psh_q;
      dsh_d  = dsh_q;
      pact_d = pact_q;
      dact_d = dact_q;
      if (wr && sel_ctrl) ctrl_d = pwdata[NUM_CH-1:0];
      if (wr && sel_ien)  ien_d  = pwdata[SW-1:0];
      // Clear first, then OR in new events so a coincident set always wins.
      if (wr && sel_stat) stat_d = stat_q & ~pwdata[SW-1:0];
      stat_d = stat_d | {fault, period_end};
      upd_d  = (upd_q & ~xfer) | per_wr | duty_wr;
      irq_d  = |(stat_q & ien_q);
      for (int c = 0; c < NUM_CH; c++) begin
         if (per_wr[c])  psh_d[c] = pwdata[CNT_WIDTH-1:0];
         if (duty_wr[c]) dsh_d[c] = pwdata[CNT_WIDTH-1:0];
         if (xfer[c]) begin
            pact_d[c] = psh_q[c];
            dact_d[c] = dsh_q[c];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_q <= '0;
         upd_q  <= '0;
         stat_q <= '0;
         ien_q  <= '0;
         irq_q  <= 1'b0;
         psh_q  <= '0;
         dsh_q  <= '0;
         pact_q <= '0;
         dact_q <= '0;
      end else begin
         ctrl_q <= ctrl_d;
         upd_q  <= upd_d;
         stat_q <= stat_d;
         ien_q  <= ien_d;
         irq_q  <= irq_d;
         psh_q  <= psh_d;
         dsh_q  <= dsh_d;
         pact_q <= pact_d;
         dact_q <= dact_d;
      end
   end

   always_comb begin
      prdata = '0;
      if (rd) begin
         if (sel_ctrl)      prdata[NUM_CH-1:0]    = ctrl_q;
         else if (sel_stat) prdata[SW-1:0]        = stat_q;
         else if (sel_ien)  prdata[SW-1:0]        = ien_q;
         else if (sel_upd)  prdata[NUM_CH-1:0]    = upd_q;
         else               prdata[CNT_WIDTH-1:0] = ch_rdata;
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign period_act[c*CNT_WIDTH +: CNT_WIDTH] = pact_q[c];
      assign duty_act[c*CNT_WIDTH +: CNT_WIDTH]   = (dact_q[c] > pact_q[c]) ? pact_q[c] : dact_q[c];
   end

   assign pwm_en = ctrl_q;
   assign irq    = irq_q;
endmodule

// File: tb/tb_pwm_reg_bank.sv
// Bench for pwm_reg_bank: directed register-map scenarios plus random APB traffic,
// each cycle compared against a per-register behavioural model of the map.
module tb_pwm_reg_bank;
   logic        clk = 1'b0, reset_n = 1'b0;
   logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [7:0]  paddr = '0;
   logic [31:0] pwdata = '0, prdata;
   logic        pready, pslverr, irq;
   logic [3:0]  period_end = '0, fault = '0, pwm_en;
   logic [63:0] period_act, duty_act;

   int          n_chk = 0, n_err = 0;
   bit          rnd_ev = 0;
   logic [31:0] rd_data;
   logic        rd_err;

   bit [3:0]    m_en, m_upd;
   bit [7:0]    m_stat, m_ien;
   bit          m_irq;
   int unsigned m_psh[4], m_dsh[4], m_pact[4], m_dact[4];

   pwm_reg_bank dut (
      .clk(clk), .reset_n(reset_n), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
      .period_end(period_end), .fault(fault), .pwm_en(pwm_en),
      .period_act(period_act), .duty_act(duty_act), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic m_reset();
      m_en = '0; m_upd = '0; m_stat = '0; m_ien = '0; m_irq = 0;
      for (int c = 0; c < 4; c++) begin
         m_psh[c] = 0; m_dsh[c] = 0; m_pact[c] = 0; m_dact[c] = 0;
      end
   endtask

   function automatic bit m_err(input bit w, input logic [7:0] a);
      if (a[1:0] != 2'b00) return 1;
      if (a == 8'h0C) return w;
      return a >= 8'h30;
   endfunction

   function automatic logic [31:0] m_read(input logic [7:0] a);
      int ch;
      case (a)
         8'h00: return {28'h0, m_en};
         8'h04: return {24'h0, m_stat};
         8'h08: return {24'h0, m_ien};
         8'h0C: return {28'h0, m_upd};
         default: begin
            ch = (int'(a) - 16) / 8;
            return a[2] ? m_dsh[ch] : m_psh[ch];
         end
      endcase
   endfunction

   function automatic logic [63:0] m_pvec();
      logic [63:0] v;
      for (int c = 0; c < 4; c++) v[c*16 +: 16] = 16'(m_pact[c]);
      return v;
   endfunction

   function automatic logic [63:0] m_dvec();
      logic [63:0] v;
      for (int c = 0; c < 4; c++)
         v[c*16 +: 16] = 16'((m_dact[c] < m_pact[c]) ? m_dact[c] : m_pact[c]);
      return v;
   endfunction

   task automatic m_step();
      bit       wr, frc;
      bit [3:0] nupd;
      int       ch;
      wr   = psel && penable && pwrite && !m_err(1'b1, paddr);
      frc  = wr && (paddr == 8'h00) && pwdata[31];
      nupd = m_upd;
      m_irq = |(m_stat & m_ien);
      for (int c = 0; c < 4; c++)
         if (frc || (period_end[c] && m_upd[c])) begin
            m_pact[c] = m_psh[c];
            m_dact[c] = m_dsh[c];
            nupd[c]   = 1'b0;
         end
      if (wr) begin
         case (paddr)
            8'h00: m_en = pwdata[3:0];
            8'h04: m_stat = m_stat & ~pwdata[7:0];
            8'h08: m_ien = pwdata[7:0];
            default: begin
               ch = (int'(paddr) - 16) / 8;
               if (paddr[2]) m_dsh[ch] = pwdata & 32'hFFFF;
               else          m_psh[ch] = pwdata & 32'hFFFF;
               nupd[ch] = 1'b1;
            end
         endcase
      end
      m_stat = m_stat | {fault, period_end};
      m_upd  = nupd;
   endtask

   task automatic tick();
      bit acc;
      if (rnd_ev) begin
         period_end = 4'($urandom) & 4'($urandom) & 4'($urandom);
         fault      = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
      end
      @(negedge clk);
      acc     = reset_n && psel && penable;
      rd_data = prdata;
      rd_err  = pslverr;
      chk("pready", pready, acc);
      chk("pslverr", pslverr, acc && m_err(pwrite, paddr));
      chk("prdata", prdata, (acc && !pwrite && !m_err(1'b0, paddr)) ? m_read(paddr) : 32'h0);
      chk("pwm_en", pwm_en, m_en);
      chk("irq", irq, m_irq);
      chk("period_act", period_act, m_pvec());
      chk("duty_act", duty_act, m_dvec());
      @(posedge clk);
      if (!reset_n) m_reset();
      else          m_step();
      #1;
   endtask

   task automatic apb(input bit w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] pe);
      psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
      tick();
      penable = 1'b1;
      if (!rnd_ev) period_end = pe;
      tick();
      psel = 1'b0; penable = 1'b0;
      if (!rnd_ev) period_end = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic pulse(input logic [3:0] pe);
      period_end = pe;
      tick();
      period_end = '0;
   endtask

   initial begin
      logic [7:0]  a;
      logic [31:0] d;
      int          idx;
      m_reset();
      idle(2);
      reset_n = 1'b1;

      for (int i = 0; i <= 'h2C; i += 4) begin
         apb(1'b0, 8'(i), 32'h0, 4'h0);
         chk("rst_rd_data", rd_data, 0);
         chk("rst_rd_err", rd_err, 0);
      end
      apb(1'b0, 8'h44, 32'h0, 4'h0);
      chk("bad_rd_err", rd_err, 1);
      chk("bad_rd_data", rd_data, 0);

      apb(1'b1, 8'h10, 32'd100, 4'h0);
      apb(1'b1, 8'h14, 32'd40, 4'h0);
      apb(1'b0, 8'h0C, 32'h0, 4'h0);
      chk("upd_pend_set", rd_data, 1);
      chk("pact0_hold", period_act[15:0], 0);
      pulse(4'h1);
      chk("pact0_xfer", period_act[15:0], 100);
      chk("dact0_xfer", duty_act[15:0], 40);
      apb(1'b0, 8'h0C, 32'h0, 4'h0);
      chk("upd_pend_clr", rd_data, 0);

      apb(1'b1, 8'h1C, 32'd300, 4'h0);
      apb(1'b1, 8'h18, 32'd200, 4'h0);
      apb(1'b1, 8'h00, 32'h8000_0000, 4'h0);
      chk("pact1_force", period_act[31:16], 200);
      chk("dact1_clamp", duty_act[31:16], 200);
      apb(1'b0, 8'h0C, 32'h0, 4'h0);
      chk("upd_after_force", rd_data, 0);
      apb(1'b0, 8'h00, 32'h0, 4'h0);
      chk("ctrl_force_rd0", rd_data, 0);

      apb(1'b1, 8'h04, 32'hFF, 4'h0);
      apb(1'b1, 8'h08, 32'h1, 4'h0);
      idle(1);
      chk("irq_idle", irq, 0);
      pulse(4'h1);
      chk("irq_latency", irq, 0);
      idle(1);
      chk("irq_set", irq, 1);
      apb(1'b0, 8'h04, 32'h0, 4'h0);
      chk("stat_pend", rd_data, 1);
      apb(1'b1, 8'h04, 32'h1, 4'h1);
      apb(1'b0, 8'h04, 32'h0, 4'h0);
      chk("w1c_set_wins", rd_data, 1);
      apb(1'b1, 8'h04, 32'h1, 4'h0);
      apb(1'b0, 8'h04, 32'h0, 4'h0);
      chk("w1c_clear", rd_data, 0);
      chk("irq_clear", irq, 0);

      apb(1'b1, 8'h0C, 32'hF, 4'h0);
      chk("wr_ro_err", rd_err, 1);
      apb(1'b1, 8'h11, 32'h1234, 4'h0);
      chk("misalign_err", rd_err, 1);
      apb(1'b0, 8'h10, 32'h0, 4'h0);
      chk("per0_kept", rd_data, 100);
      apb(1'b0, 8'h0C, 32'h0, 4'h0);
      chk("upd_kept", rd_data, 0);

      apb(1'b1, 8'h10, 32'd77, 4'h0);
      apb(1'b1, 8'h10, 32'd50, 4'h1);
      chk("xfer_old_shadow", period_act[15:0], 77);
      apb(1'b0, 8'h0C, 32'h0, 4'h0);
      chk("upd_stays", rd_data, 1);
      apb(1'b0, 8'h10, 32'h0, 4'h0);
      chk("shadow_new", rd_data, 50);

      apb(1'b1, 8'h00, 32'hF, 4'h0);
      chk("pwm_en_on", pwm_en, 4'hF);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'hFFFF;
      tick();
      penable = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      chk("rst_mid_pready", pready, 0);
      chk("rst_mid_pslverr", pslverr, 0);
      chk("rst_mid_prdata", prdata, 0);
      chk("rst_mid_pwm_en", pwm_en, 0);
      chk("rst_mid_pact", period_act, 0);
      chk("rst_mid_dact", duty_act, 0);
      chk("rst_mid_irq", irq, 0);
      m_reset();
      @(posedge clk);
      #1 psel = 1'b0; penable = 1'b0;
      #1 reset_n = 1'b1;
      apb(1'b0, 8'h00, 32'h0, 4'h0);
      chk("ctrl_after_rst", rd_data, 0);
      chk("pwm_en_after_rst", pwm_en, 0);

      rnd_ev = 1;
      repeat (300) begin
         idx = $urandom_range(0, 17);
         if (idx < 16)       a = 8'(idx * 4);
         else if (idx == 16) a = 8'h11;
         else                a = 8'h0E;
         d = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 400));
         apb(1'($urandom_range(0, 1)), a, d, 4'h0);
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      rnd_ev = 0;
      period_end = '0;
      fault = '0;
      idle(2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
